comp_mac_pipe: RTL and testbench
================================

COMP_MAC_PIPE -- requirements
Module: comp_mac_pipe

Interface
REQ-001 SHALL have parameter AW, default 25, meaning signed width of A operand components.
REQ-002 SHALL have parameter BW, default 18, meaning signed width of B operand components.
REQ-003 SHALL have parameter PW, default 48, meaning signed width of product/accumulator components.
REQ-004 SHALL have parameter CW, default 8, meaning width of accumulated-sample counter.
REQ-005 SHALL have port CLK input 1: single clock, all state on rising edge.
REQ-006 SHALL have port RST_N input 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports A_REAL, A_IMAGINARY input AW: signed complex operand A.
REQ-008 SHALL have ports B_REAL, B_IMAGINARY input BW: signed complex operand B.
REQ-009 SHALL have port IN_VALID input 1: operands valid this cycle.
REQ-010 SHALL have port IN_LAST input 1: final sample of an accumulation group.
REQ-011 SHALL have port MODE input 1: 0 = multiply per sample, 1 = accumulate; sampled with IN_VALID.
REQ-012 SHALL have ports PROD_REAL, PROD_IMAGINARY output PW: signed result.
REQ-013 SHALL have port OUT_VALID output 1: result valid, one-cycle pulse per result.
REQ-014 SHALL have port OUT_CNT output CW: number of samples in the presented result.

Function
REQ-015 SHALL compute real = Ar*Br - Ai*Bi, imag = Ar*Bi + Ai*Br, all signed, sign-extended to PW before add/sub.
REQ-016 SHALL be a 4-stage pipeline: S1 input register, S2 four partial products, S3 add/sub, S4 accumulate/output register; IN_VALID, IN_LAST, MODE travel alongside data.
REQ-017 SHALL accept one sample per cycle, no backpressure; bubbles (IN_VALID=0) propagate, change no state in S4.
REQ-018 Mode 0: SHALL assert OUT_VALID exactly 4 cycles after IN_VALID with that sample's product, OUT_CNT=1; IN_LAST ignored.
REQ-019 Mode 1: S4 accumulator SHALL be in state IDLE or ACC; first valid sample loads accumulator and sets count=1 (IDLE->ACC); further samples add, count+1.
REQ-020 Mode 1: sample with IN_LAST SHALL produce OUT_VALID 4 cycles after its input with sum including itself, then return to IDLE (accumulator and count cleared in same edge).
REQ-021 A mode-0 sample reaching S4 while in ACC SHALL discard the open group (no output for it), output its own product, return to IDLE.
REQ-022 Accumulator SHALL wrap modulo 2^PW per component; OUT_CNT SHALL saturate at 2^CW-1.
REQ-023 PROD_REAL/PROD_IMAGINARY/OUT_CNT SHALL hold last result while OUT_VALID=0.
REQ-024 Single-sample group (first sample has IN_LAST, mode 1) SHALL output its product with OUT_CNT=1.

Reset
REQ-025 RST_N low SHALL immediately clear all pipeline valid bits, accumulator, count, state=IDLE; outputs 0, OUT_VALID 0.
REQ-026 Reset mid-group or mid-pipeline SHALL drop in-flight samples; no output after release until new samples traverse 4 stages.

Configuration
REQ-027 With COMP_MAC_CONJ_EN defined SHALL add input port CONJ (1 bit, sampled with IN_VALID); CONJ=1 computes A*conj(B): real = Ar*Br + Ai*Bi, imag = Ai*Br - Ar*Bi.
REQ-028 Without COMP_MAC_CONJ_EN port CONJ SHALL not exist and behaviour equals CONJ=0.

Structure
REQ-029 Shared package comp_dsp_pkg SHALL hold default width constants, MODE encodings and accumulator state typedef (IDLE, ACC).
REQ-030 Partial-product/add stages (S1-S3) SHALL be sub-module comp_mult_core, reusable without accumulator.

Verification
REQ-031 Mode 0, A=2+2j, B=6+2j -> 4 cycles later OUT_VALID, PROD=8+16j, OUT_CNT=1.
REQ-032 Mode 0 back-to-back, A=2020+2000j, B=2020+2020j following REQ-031 -> consecutive outputs 8+16j then 40400+8120400j.
REQ-033 Mode 1 group (2+2j)(6+2j), (2020+2000j)(2020+2020j), (10+14j)(10+10j) LAST -> single output 40368+8120656j, OUT_CNT=3.
REQ-034 Negative: A=-3+0j, B=5+0j mode 0 -> PROD_REAL=48'hFFFFFFFFFFF1, IMAG=0.
REQ-035 COMP_MAC_CONJ_EN, CONJ=1, A=2+2j, B=6+2j -> PROD=16+8j.
REQ-036 RST_N low for 1 cycle mid-group after 2 samples -> no output; next group LAST with 1 sample (10+14j)(10+10j) -> -40+240j, OUT_CNT=1.

Source files
------------

// File: rtl/comp_dsp_pkg.sv
// Shared widths, MODE encodings and accumulator state for the complex MAC blocks.
package comp_dsp_pkg;

  localparam int DEF_AW = 25;
  localparam int DEF_BW = 18;
  localparam int DEF_PW = 48;
  localparam int DEF_CW = 8;

  localparam logic MODE_MULT = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/comp_mult_core.sv
// Three-stage complex multiplier: S1 input register, S2 partial products, S3 add/sub.
// The conj input selects A*conj(B); control bits travel alongside the data.
module comp_mult_core #(
  parameter int AW = 25,
  parameter int BW = 18,
  parameter int PW = 48
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic signed [AW-1:0] a_real,
  input  logic signed [AW-1:0] a_imag,
  input  logic signed [BW-1:0] b_real,
  input  logic signed [BW-1:0] b_imag,
  input  logic                 valid,
  input  logic                 last,
  input  logic                 mode,
  input  logic                 conj,
  output logic signed [PW-1:0] sum_real,
  output logic signed [PW-1:0] sum_imag,
  output logic                 sum_valid,
  output logic                 sum_last,
  output logic                 sum_mode
);

  localparam int MW = AW + BW;

  logic signed [AW-1:0] a_real_reg, a_imag_reg;
  logic signed [BW-1:0] b_real_reg, b_imag_reg;
  logic                 s1_valid_reg, s1_last_reg, s1_mode_reg, s1_conj_reg;
  logic                 s2_valid_reg, s2_last_reg, s2_mode_reg, s2_conj_reg;
  logic signed [PW-1:0] sum_real_reg, sum_imag_reg;
  logic                 s3_valid_reg, s3_last_reg, s3_mode_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_real_reg   <= '0;
      a_imag_reg   <= '0;
      b_real_reg   <= '0;
      b_imag_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_mode_reg  <= 1'b0;
      s1_conj_reg  <= 1'b0;
    end else begin
      a_real_reg   <= a_real;
      a_imag_reg   <= a_imag;
      b_real_reg   <= b_real;
      b_imag_reg   <= b_imag;
      s1_valid_reg <= valid;
      s1_last_reg  <= last;
      s1_mode_reg  <= mode;
      s1_conj_reg  <= conj;
    end
  end

  // Partial product gi: 0 = Ar*Br, 1 = Ai*Bi, 2 = Ar*Bi, 3 = Ai*Br
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pp
      localparam bit USE_AI = (gi == 1) || (gi == 3);
      localparam bit USE_BI = (gi == 1) || (gi == 2);
      logic signed [MW-1:0] a_ext, b_ext, prod;
      logic signed [PW-1:0] pp_reg;

      assign a_ext = USE_AI ? MW'(a_imag_reg) : MW'(a_real_reg);
      assign b_ext = USE_BI ? MW'(b_imag_reg) : MW'(b_real_reg);
      assign prod  = a_ext * b_ext;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) pp_reg <= '0;
        else        pp_reg <= PW'(prod);
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s2_mode_reg  <= 1'b0;
      s2_conj_reg  <= 1'b0;
      sum_real_reg <= '0;
      sum_imag_reg <= '0;
      s3_valid_reg <= 1'b0;
      s3_last_reg  <= 1'b0;
      s3_mode_reg  <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
      s2_mode_reg  <= s1_mode_reg;
      s2_conj_reg  <= s1_conj_reg;
      if (s2_conj_reg) begin
        sum_real_reg <= g_pp[0].pp_reg + g_pp[1].pp_reg;
        sum_imag_reg <= g_pp[3].pp_reg - g_pp[2].pp_reg;
      end else begin
        sum_real_reg <= g_pp[0].pp_reg - g_pp[1].pp_reg;
        sum_imag_reg <= g_pp[2].pp_reg + g_pp[3].pp_reg;
      end
      s3_valid_reg <= s2_valid_reg;
      s3_last_reg  <= s2_last_reg;
      s3_mode_reg  <= s2_mode_reg;
    end
  end

  assign sum_real  = sum_real_reg;
  assign sum_imag  = sum_imag_reg;
  assign sum_valid = s3_valid_reg;
  assign sum_last  = s3_last_reg;
  assign sum_mode  = s3_mode_reg;

endmodule

// File: rtl/comp_mac_pipe.sv
// Four-stage complex multiply / accumulate: comp_mult_core (S1-S3) plus S4 accumulator.
// Define COMP_MAC_CONJ_EN to add the CONJ input (A*conj(B)); otherwise plain A*B.
module comp_mac_pipe
  import comp_dsp_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int BW = DEF_BW,
  parameter int PW = DEF_PW,
  parameter int CW = DEF_CW
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic signed [AW-1:0] A_REAL,
  input  logic signed [AW-1:0] A_IMAGINARY,
  input  logic signed [BW-1:0] B_REAL,
  input  logic signed [BW-1:0] B_IMAGINARY,
  input  logic                 IN_VALID,
  input  logic                 IN_LAST,
  input  logic                 MODE,
`ifdef COMP_MAC_CONJ_EN
  input  logic                 CONJ,
`endif
  output logic signed [PW-1:0] PROD_REAL,
  output logic signed [PW-1:0] PROD_IMAGINARY,
  output logic                 OUT_VALID,
  output logic [CW-1:0]        OUT_CNT
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic                 conj;
  logic signed [PW-1:0] s3_real, s3_imag;
  logic                 s3_valid, s3_last, s3_mode;

`ifdef COMP_MAC_CONJ_EN
  assign conj = CONJ;
`else
  assign conj = 1'b0;
`endif

  comp_mult_core #(
    .AW(AW),
    .BW(BW),
    .PW(PW)
  ) u_core (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .a_real    (A_REAL),
    .a_imag    (A_IMAGINARY),
    .b_real    (B_REAL),
    .b_imag    (B_IMAGINARY),
    .valid     (IN_VALID),
    .last      (IN_LAST),
    .mode      (MODE),
    .conj      (conj),
    .sum_real  (s3_real),
    .sum_imag  (s3_imag),
    .sum_valid (s3_valid),
    .sum_last  (s3_last),
    .sum_mode  (s3_mode)
  );

  acc_state_t           state_reg, state_next;
  logic signed [PW-1:0] acc_real_reg, acc_imag_reg;
  logic [CW-1:0]        cnt_reg;
  logic signed [PW-1:0] prod_real_reg, prod_imag_reg;
  logic [CW-1:0]        out_cnt_reg;
  logic                 out_valid_reg;
  logic                 emit_prod, emit_sum, load_acc;
  logic                 grp_open;
  logic signed [PW-1:0] grp_real, grp_imag;
  logic [CW-1:0]        grp_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (s3_valid) begin
      if (s3_mode == MODE_ACC && !s3_last) state_next = ACC;
      else                                 state_next = IDLE;
    end
  end

  always_comb begin
    emit_prod = 1'b0;
    emit_sum  = 1'b0;
    load_acc  = 1'b0;
    if (s3_valid) begin
      if (s3_mode == MODE_MULT) emit_prod = 1'b1;
      else if (s3_last)         emit_sum  = 1'b1;
      else                      load_acc  = 1'b1;
    end
  end

  // Running group value including the sample currently in S3
  assign grp_open = (state_reg == ACC);
  assign grp_real = (grp_open ? acc_real_reg : '0) + s3_real;
  assign grp_imag = (grp_open ? acc_imag_reg : '0) + s3_imag;
  assign grp_cnt  = !grp_open ? CW'(1) :
                    (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_real_reg  <= '0;
      acc_imag_reg  <= '0;
      cnt_reg       <= '0;
      prod_real_reg <= '0;
      prod_imag_reg <= '0;
      out_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= emit_prod | emit_sum;
      if (load_acc) begin
        acc_real_reg <= grp_real;
        acc_imag_reg <= grp_imag;
        cnt_reg      <= grp_cnt;
      end else if (emit_prod || emit_sum) begin
        acc_real_reg <= '0;
        acc_imag_reg <= '0;
        cnt_reg      <= '0;
      end
      if (emit_prod) begin
        prod_real_reg <= s3_real;
        prod_imag_reg <= s3_imag;
        out_cnt_reg   <= CW'(1);
      end else if (emit_sum) begin
        prod_real_reg <= grp_real;
        prod_imag_reg <= grp_imag;
        out_cnt_reg   <= grp_cnt;
      end
    end
  end

  assign PROD_REAL      = prod_real_reg;
  assign PROD_IMAGINARY = prod_imag_reg;
  assign OUT_CNT        = out_cnt_reg;
  assign OUT_VALID      = out_valid_reg;

endmodule

// File: tb/tb_comp_mac_pipe.sv
// Scoreboard bench for comp_mac_pipe: directed vectors, random traffic, count saturation.
// A group-level reference model pushes expected results; a monitor pops them on OUT_VALID.
module tb_comp_mac_pipe;

  localparam int AW = 25;
  localparam int BW = 18;
  localparam int PW = 48;
  localparam int CW = 8;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [AW-1:0] A_REAL = '0, A_IMAGINARY = '0;
  logic [BW-1:0] B_REAL = '0, B_IMAGINARY = '0;
  logic          IN_VALID = 1'b0, IN_LAST = 1'b0, MODE = 1'b0;
`ifdef COMP_MAC_CONJ_EN
  logic          CONJ = 1'b0;
`endif
  logic [PW-1:0] PROD_REAL, PROD_IMAGINARY;
  logic          OUT_VALID;
  logic [CW-1:0] OUT_CNT;

  comp_mac_pipe dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .A_REAL         (A_REAL),
    .A_IMAGINARY    (A_IMAGINARY),
    .B_REAL         (B_REAL),
    .B_IMAGINARY    (B_IMAGINARY),
    .IN_VALID       (IN_VALID),
    .IN_LAST        (IN_LAST),
    .MODE           (MODE),
`ifdef COMP_MAC_CONJ_EN
    .CONJ           (CONJ),
`endif
    .PROD_REAL      (PROD_REAL),
    .PROD_IMAGINARY (PROD_IMAGINARY),
    .OUT_VALID      (OUT_VALID),
    .OUT_CNT        (OUT_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] re;
    logic [PW-1:0] im;
    logic [CW-1:0] cnt;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  logic [PW-1:0] last_re = '0, last_im = '0;
  logic [CW-1:0] last_cnt = '0;

  // Reference model state: the currently open accumulation group
  bit            grp_open = 1'b0;
  logic [PW-1:0] grp_re, grp_im;
  int            grp_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST_N) begin
      if (OUT_VALID) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got re=%0h im=%0h cnt=%0d expected none (cycle %0d)",
                   PROD_REAL, PROD_IMAGINARY, OUT_CNT, cyc);
        end else begin
          e = sb.pop_front();
          check("prod_real", 64'(PROD_REAL), 64'(e.re));
          check("prod_imag", 64'(PROD_IMAGINARY), 64'(e.im));
          check("out_cnt", 64'(OUT_CNT), 64'(e.cnt));
          check("latency", 64'(cyc), 64'(e.due));
          last_re  = e.re;
          last_im  = e.im;
          last_cnt = e.cnt;
          $display("result cyc=%0d re=%0h im=%0h cnt=%0d", cyc, PROD_REAL, PROD_IMAGINARY, OUT_CNT);
        end
      end else begin
        check("hold_real", 64'(PROD_REAL), 64'(last_re));
        check("hold_imag", 64'(PROD_IMAGINARY), 64'(last_im));
        check("hold_cnt", 64'(OUT_CNT), 64'(last_cnt));
      end
    end
  end

  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input bit mode, input bit last, input bit conj);
    longint pr, pi;
    exp_t   e;
    if (conj) begin
      pr = longint'(ar) * br + longint'(ai) * bi;
      pi = longint'(ai) * br - longint'(ar) * bi;
    end else begin
      pr = longint'(ar) * br - longint'(ai) * bi;
      pi = longint'(ar) * bi + longint'(ai) * br;
    end
    @(negedge CLK);
    A_REAL      = AW'(ar);
    A_IMAGINARY = AW'(ai);
    B_REAL      = BW'(br);
    B_IMAGINARY = BW'(bi);
    IN_VALID    = 1'b1;
    IN_LAST     = last;
    MODE        = mode;
`ifdef COMP_MAC_CONJ_EN
    CONJ        = conj;
`endif
    e.due = cyc + 4;
    if (!mode) begin
      grp_open = 1'b0;
      e.re = pr[PW-1:0];
      e.im = pi[PW-1:0];
      e.cnt = CW'(1);
      sb.push_back(e);
    end else begin
      if (!grp_open) begin
        grp_re = pr[PW-1:0];
        grp_im = pi[PW-1:0];
        grp_n  = 1;
        grp_open = 1'b1;
      end else begin
        grp_re = grp_re + pr[PW-1:0];
        grp_im = grp_im + pi[PW-1:0];
        grp_n  = (grp_n >= CNT_SAT) ? CNT_SAT : grp_n + 1;
      end
      if (last) begin
        e.re = grp_re;
        e.im = grp_im;
        e.cnt = CW'(grp_n);
        sb.push_back(e);
        grp_open = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      IN_VALID    = 1'b0;
      A_REAL      = AW'($urandom);
      A_IMAGINARY = AW'($urandom);
      B_REAL      = BW'($urandom);
      B_IMAGINARY = BW'($urandom);
      IN_LAST     = 1'($urandom);
      MODE        = 1'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RST_N    = 1'b0;
    IN_VALID = 1'b0;
    sb.delete();
    grp_open = 1'b0;
    last_re  = '0;
    last_im  = '0;
    last_cnt = '0;
    #1;
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_prod_real", 64'(PROD_REAL), 64'd0);
    check("rst_prod_imag", 64'(PROD_IMAGINARY), 64'd0);
    check("rst_out_cnt", 64'(OUT_CNT), 64'd0);
    repeat (n) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  function automatic int rnd_s(input int w);
    return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
  endfunction

  initial begin
    bit cj;
    repeat (2) @(negedge CLK);
    do_reset(3);

    // Back-to-back multiplies, then a three-sample group
    send(2, 2, 6, 2, 1'b0, 1'b0, 1'b0);
    send(2020, 2000, 2020, 2020, 1'b0, 1'b1, 1'b0);
    idle(2);
    send(2, 2, 6, 2, 1'b1, 1'b0, 1'b0);
    send(2020, 2000, 2020, 2020, 1'b1, 1'b0, 1'b0);
    send(10, 14, 10, 10, 1'b1, 1'b1, 1'b0);
    idle(1);
    send(-3, 0, 5, 0, 1'b0, 1'b0, 1'b0);
    idle(3);
`ifdef COMP_MAC_CONJ_EN
    send(2, 2, 6, 2, 1'b0, 1'b0, 1'b1);
    idle(2);
`endif
    // Open group interrupted by a multiply sample, then single-sample group
    send(7, -9, 100, 3, 1'b1, 1'b0, 1'b0);
    send(-50, 4, 8, -8, 1'b1, 1'b0, 1'b0);
    send(11, 12, 13, 14, 1'b0, 1'b0, 1'b0);
    send(-1, -1, -1, 1, 1'b1, 1'b1, 1'b0);
    idle(5);

    // Reset after two group samples: nothing may emerge from them
    send(2, 2, 6, 2, 1'b1, 1'b0, 1'b0);
    send(2020, 2000, 2020, 2020, 1'b1, 1'b0, 1'b0);
    do_reset(1);
    idle(6);
    send(10, 14, 10, 10, 1'b1, 1'b1, 1'b0);
    idle(5);

    // Random traffic with bubbles, mixed modes and LAST
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else begin
`ifdef COMP_MAC_CONJ_EN
        cj = 1'($urandom);
`else
        cj = 1'b0;
`endif
        send(rnd_s(AW), rnd_s(AW), rnd_s(BW), rnd_s(BW),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), cj);
      end
    end
    idle(5);

    // Long group of extreme operands: count saturates and sums wrap
    for (int i = 0; i < 300; i++)
      send(-(1 << (AW - 1)), -(1 << (AW - 1)), -(1 << (BW - 1)), (1 << (BW - 1)) - 1,
           1'b1, (i == 299), 1'b0);
    idle(8);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
